cache_2way_wt: RTL and testbench

CACHE_2WAY_WT -- requirements
Module: cache_2way_wt

---
 rtl/cache_2way_wt.sv | 153 +++++++++++++++
 tb/tb_cache_2way_wt.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cache_2way_wt.sv
// cache_2way_wt: 2-way set-associative write-through, no-write-allocate cache, one word per line,
// with a blocking single-outstanding backing-memory port and saturating hit/miss counters.
module cache_2way_wt #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              flush,
  input  logic [ADDR_W-1:0] WordAddress,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int SETS  = 1 << INDEX_W;
  typedef enum logic [1:0] {IDLE, RD_MISS, WR_MEM, WR_DONE} state_t;
  state_t              state_q, state_d;
  logic [SETS-1:0]     valid_q [2], valid_d [2];
  logic [SETS-1:0]     lru_q, lru_d;
  logic [TAG_W-1:0]    tag_q [2][SETS], tag_d [2][SETS];
  logic [DATA_W-1:0]   data_q [2][SETS], data_d [2][SETS];
  logic [DATA_W-1:0]   dout_q, dout_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                req_q, req_d, we_q, we_d, refill_q, refill_d;
  logic [15:0]         hits_q, hits_d, misses_q, misses_d;
  logic [ADDR_W-1:0]   lk_addr;
  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic                hit0, hit1, hit, victim;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
  // Outside IDLE the lookup runs on the latched address so a write ack can test for a hit.
  assign lk_addr = (state_q == IDLE) ? WordAddress : addr_q;
  assign idx     = lk_addr[INDEX_W-1:0];
  assign tag     = lk_addr[ADDR_W-1:INDEX_W];
  assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit     = hit0 || hit1;
  assign victim  = !valid_q[0][idx] ? 1'b0 : !valid_q[1][idx] ? 1'b1 : lru_q[idx];
  assign stall   = (state_q == IDLE) ? (flush || mem_write || (mem_read && !hit)) : (state_q != WR_DONE);
  assign DataOut    = dout_q;
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign hit_count  = hits_q;
  assign miss_count = misses_q;
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    lru_d    = lru_q;
    tag_d    = tag_q;
    data_d   = data_q;
    dout_d   = dout_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    req_d    = req_q;
    we_d     = we_q;
    refill_d = refill_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    case (state_q)
      IDLE: begin
        refill_d = 1'b0;
        if (flush) begin
          valid_d[0] = '0;
          valid_d[1] = '0;
          lru_d      = '0;
        end else if (mem_write) begin
          state_d = WR_MEM;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = WordAddress;
          wdata_d = DataIn;
        end else if (mem_read && hit) begin
          dout_d     = data_q[hit1][idx];
          lru_d[idx] = !hit1;
          hits_d     = refill_q ? hits_q : sat_inc(hits_q);
        end else if (mem_read) begin
          state_d  = RD_MISS;
          req_d    = 1'b1;
          we_d     = 1'b0;
          addr_d   = WordAddress;
          misses_d = sat_inc(misses_q);
        end
      end
      RD_MISS: if (mem_ack) begin
        valid_d[victim][idx] = 1'b1;
        tag_d[victim][idx]   = tag;
        data_d[victim][idx]  = mem_rdata;
        lru_d[idx]           = !victim;
        req_d                = 1'b0;
        refill_d             = 1'b1;
        state_d              = IDLE;
      end
      WR_MEM: if (mem_ack) begin
        if (hit) begin
          data_d[hit1][idx] = wdata_q;
          lru_d[idx]        = !hit1;
          hits_d            = sat_inc(hits_q);
        end else misses_d = sat_inc(misses_q);
        req_d   = 1'b0;
        we_d    = 1'b0;
        state_d = WR_DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      valid_q  <= '{default: '0};
      lru_q    <= '0;
      tag_q    <= '{default: '{default: '0}};
      data_q   <= '{default: '{default: '0}};
      dout_q   <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      refill_q <= 1'b0;
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      lru_q    <= lru_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      dout_q   <= dout_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      we_q     <= we_d;
      refill_q <= refill_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end
endmodule

// File: tb/tb_cache_2way_wt.sv
// tb_cache_2way_wt: directed vectors for cache_2way_wt against a backing memory that acks
// in the third cycle of each request.
module tb_cache_2way_wt;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, flush = 1'b0;
  logic [9:0]  WordAddress = '0;
  logic [31:0] DataIn = '0, mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] DataOut, mem_wdata;
  logic        stall, mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] hit_count, miss_count;
  logic [31:0] mem [1024];
  int          n_vec = 0, n_err = 0, ack_cnt = 0, sc = 0;
  logic        seen_req, seen_we;
  logic [9:0]  seen_addr;
  logic [31:0] seen_wdata;
  cache_2way_wt dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .flush(flush),
    .WordAddress(WordAddress), .DataIn(DataIn), .DataOut(DataOut), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  // One clock edge, then the memory model reacts to what the DUT now presents.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_ack) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (mem_req) begin
      ack_cnt++;
      if (ack_cnt == 3) begin
        mem_ack = 1'b1;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else mem_rdata = mem[mem_addr];
      end
    end else ack_cnt = 0;
  endtask
  task automatic access(input logic wr, input logic [9:0] a, input logic [31:0] d, output int stalls);
    mem_read = !wr;
    mem_write = wr;
    WordAddress = a;
    DataIn = d;
    stalls = 0;
    seen_req = 1'b0;
    #1;
    while (stall && stalls < 50) begin
      if (mem_req) begin
        seen_req = 1'b1;
        seen_addr = mem_addr;
        seen_we = mem_we;
        seen_wdata = mem_wdata;
      end
      stalls++;
      tick();
      #1;
    end
    if (stalls >= 50) chk("stall_timeout", 32'(stalls), 32'd0);
    tick();
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    tick();
    #1;
    chk("rst_dataout", DataOut, 32'h0);
    chk("rst_hits", 32'(hit_count), 32'd0);
    chk("rst_misses", 32'(miss_count), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall_idle", 32'(stall), 32'd0);
    access(1'b0, 10'h005, '0, sc);
    chk("miss005_stalls", 32'(sc), 32'd4);
    chk("miss005_req_seen", 32'(seen_req), 32'd1);
    chk("miss005_addr", 32'(seen_addr), 32'h005);
    chk("miss005_we", 32'(seen_we), 32'd0);
    chk("miss005_data", DataOut, 32'hA000_0005);
    chk("miss005_misses", 32'(miss_count), 32'd1);
    chk("miss005_hits", 32'(hit_count), 32'd0);
    access(1'b0, 10'h005, '0, sc);
    chk("hit005_stalls", 32'(sc), 32'd0);
    chk("hit005_data", DataOut, 32'hA000_0005);
    chk("hit005_hits", 32'(hit_count), 32'd1);
    access(1'b0, 10'h00D, '0, sc);
    chk("miss00D_stalls", 32'(sc), 32'd4);
    chk("miss00D_data", DataOut, 32'hA000_000D);
    access(1'b0, 10'h015, '0, sc);
    chk("miss015_stalls", 32'(sc), 32'd4);
    chk("miss015_data", DataOut, 32'hA000_0015);
    access(1'b0, 10'h00D, '0, sc);
    chk("rehit00D_stalls", 32'(sc), 32'd0);
    chk("rehit00D_data", DataOut, 32'hA000_000D);
    access(1'b0, 10'h005, '0, sc);
    chk("evicted005_stalls", 32'(sc), 32'd4);
    chk("evicted005_data", DataOut, 32'hA000_0005);
    chk("set5_misses", 32'(miss_count), 32'd4);
    chk("set5_hits", 32'(hit_count), 32'd2);
    access(1'b1, 10'h00D, 32'hDEAD_BEEF, sc);
    chk("wr00D_stalls", 32'(sc), 32'd4);
    chk("wr00D_we", 32'(seen_we), 32'd1);
    chk("wr00D_addr", 32'(seen_addr), 32'h00D);
    chk("wr00D_wdata", seen_wdata, 32'hDEAD_BEEF);
    chk("wr00D_hits", 32'(hit_count), 32'd3);
    #1;
    chk("wr_done_idle_stall", 32'(stall), 32'd0);
    access(1'b0, 10'h00D, '0, sc);
    chk("rd00D_after_wr_stalls", 32'(sc), 32'd0);
    chk("rd00D_after_wr_data", DataOut, 32'hDEAD_BEEF);
    chk("rd00D_after_wr_hits", 32'(hit_count), 32'd4);
    access(1'b1, 10'h3F0, 32'h1234_5678, sc);
    chk("wr3F0_misses", 32'(miss_count), 32'd5);
    chk("wr3F0_hits", 32'(hit_count), 32'd4);
    chk("wr3F0_dataout_held", DataOut, 32'hDEAD_BEEF);
    access(1'b0, 10'h3F0, '0, sc);
    chk("rd3F0_stalls", 32'(sc), 32'd4);
    chk("rd3F0_data", DataOut, 32'h1234_5678);
    chk("rd3F0_misses", 32'(miss_count), 32'd6);
    flush = 1'b1;
    #1;
    chk("flush_stall", 32'(stall), 32'd1);
    tick();
    flush = 1'b0;
    access(1'b0, 10'h00D, '0, sc);
    chk("post_flush_stalls", 32'(sc), 32'd4);
    chk("post_flush_misses", 32'(miss_count), 32'd7);
    mem_read = 1'b1;
    WordAddress = 10'h015;
    tick();
    tick();
    #1;
    chk("rdmiss_req_up", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_addr", 32'(mem_addr), 32'h000);
    chk("midrst_misses", 32'(miss_count), 32'd0);
    chk("midrst_dataout", DataOut, 32'h0);
    chk("midrst_stall_rule", 32'(stall), 32'd1);
    mem_read = 1'b0;
    tick();
    reset = 1'b1;
    mem_ack = 1'b1;
    tick();
    #1;
    chk("late_ack_req", 32'(mem_req), 32'd0);
    chk("late_ack_misses", 32'(miss_count), 32'd0);
    chk("late_ack_hits", 32'(hit_count), 32'd0);
    access(1'b0, 10'h015, '0, sc);
    chk("post_rst_015_stalls", 32'(sc), 32'd4);
    chk("post_rst_015_data", DataOut, 32'hA000_0015);
    chk("post_rst_015_misses", 32'(miss_count), 32'd1);
    chk("post_rst_refill_hits", 32'(hit_count), 32'd0);
    mem_read = 1'b1;
    WordAddress = 10'h015;
    sc = 0;
    while (hit_count != 16'hFFFF && sc < 70000) begin
      tick();
      sc++;
    end
    chk("sat_cycles", 32'(sc), 32'd65535);
    repeat (3) tick();
    mem_read = 1'b0;
    #1;
    chk("sat_hits", 32'(hit_count), 32'hFFFF);
    chk("sat_misses", 32'(miss_count), 32'd1);
    chk("sat_data", DataOut, 32'hA000_0015);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
